// File: rtl/uart_axis_pkg.sv
// Shared types and helpers for the UART-to-AXI-Stream receive path.
package uart_axis_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Parity bit the transmitter should have sent for this data byte.
    function automatic logic parity_bit(input logic [BYTE_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; writes to a full FIFO are dropped
// and flagged unless a read frees the slot in the same cycle.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_valid_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_ready_i,
    output logic                     rd_valid_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             overflow_q;
    logic             full, pop, push_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop     = rd_valid_o && rd_ready_i;
    assign push_ok = wr_valid_i && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_valid_i && full && !pop;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_valid_o = (level_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_rx_axis_packer.sv
// Oversampling UART receiver that packs accepted bytes little-endian into
// AXI4-Stream beats, flushing a partial beat after an idle-line timeout.
module uart_rx_axis_packer
    import uart_axis_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT      = 868,
    parameter int unsigned SYNC_STAGES       = 3,
    parameter int unsigned BYTES_PER_BEAT    = 4,
    parameter int unsigned PARITY_EN         = 0,
    parameter int unsigned PARITY_ODD        = 0,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned IDLE_TIMEOUT_BITS = 20
) (
    input  logic                          M_AXIS_ACLK,
    input  logic                          M_AXIS_ARESETN,
    input  logic                          rx_din,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TVALID,
    output logic [8*BYTES_PER_BEAT-1:0]   M_AXIS_TDATA,
    output logic [BYTES_PER_BEAT-1:0]     M_AXIS_TKEEP,
    output logic                          M_AXIS_TLAST,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DATA_W     = BYTE_W * BYTES_PER_BEAT;
    localparam int unsigned FIFO_W     = DATA_W + BYTES_PER_BEAT + 1;
    localparam int unsigned CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int unsigned K_W        = $clog2(BYTES_PER_BEAT + 1);
    localparam int unsigned TO_MAX     = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_LIM     = (TO_MAX > 0) ? TO_MAX : 1;
    localparam int unsigned TO_W       = $clog2(TO_LIM + 1);
    localparam bit          TIMEOUT_EN = (IDLE_TIMEOUT_BITS != 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev_q, start_edge;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) sync_q <= '1;
        else                 sync_q <= {sync_q[SYNC_STAGES-2:0], rx_din};
    end

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_prev_q && !rx_s;

    rx_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_q;
    logic [BYTE_W-1:0]  shift_q, byte_q;
    logic               par_ok_q, byte_vld_q, frame_err_q, parity_err_q;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q      <= ST_IDLE;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            par_ok_q     <= 1'b1;
            byte_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_prev_q    <= rx_s;
            byte_vld_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT / 2)) begin
                        cnt_q    <= '0;
                        bit_q    <= '0;
                        par_ok_q <= 1'b1;
                        state_q  <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[BYTE_W-1:1]};
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
                            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q    <= '0;
                        par_ok_q <= (rx_s == parity_bit(shift_q, PARITY_ODD != 0));
                        state_q  <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q <= '0;
                        if (rx_s && par_ok_q) begin
                            byte_q     <= shift_q;
                            byte_vld_q <= 1'b1;
                        end
                        frame_err_q  <= !rx_s;
                        parity_err_q <= !par_ok_q;
                        state_q      <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [TO_W-1:0]           to_q;
    logic [K_W-1:0]            k_q;
    logic [DATA_W-1:0]         lanes_q;
    logic                      push_q;
    logic [FIFO_W-1:0]         push_beat_q;
    logic [BYTES_PER_BEAT-1:0] keep_d;
    logic                      flush;

    always_comb begin
        keep_d = '0;
        for (int unsigned i = 0; i < BYTES_PER_BEAT; i++) keep_d[i] = (K_W'(i) < k_q);
    end

    // One-shot: fires only on the cycle the saturating counter reaches its limit.
    assign flush = TIMEOUT_EN && (state_q == ST_IDLE) && !start_edge &&
                   (to_q == TO_W'(TO_LIM - 1)) && (k_q != '0);

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            to_q        <= '0;
            k_q         <= '0;
            lanes_q     <= '0;
            push_q      <= 1'b0;
            push_beat_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (start_edge)
                to_q <= '0;
            else if (state_q == ST_IDLE && to_q != TO_W'(TO_LIM))
                to_q <= to_q + 1'b1;

            if (byte_vld_q) begin
                for (int unsigned i = 0; i < BYTES_PER_BEAT; i++)
                    if (k_q == K_W'(i)) lanes_q[BYTE_W*i +: BYTE_W] <= byte_q;
                k_q <= k_q + 1'b1;
            end else if (k_q == K_W'(BYTES_PER_BEAT)) begin
                push_q      <= 1'b1;
                push_beat_q <= {1'b0, {BYTES_PER_BEAT{1'b1}}, lanes_q};
                k_q         <= '0;
                lanes_q     <= '0;
            end else if (flush) begin
                push_q      <= 1'b1;
                push_beat_q <= {1'b1, keep_d, lanes_q};
                k_q         <= '0;
                lanes_q     <= '0;
            end
        end
    end

    logic [FIFO_W-1:0] fifo_out;

    axis_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (M_AXIS_ACLK),
        .rst_ni     (M_AXIS_ARESETN),
        .wr_valid_i (push_q),
        .wr_data_i  (push_beat_q),
        .rd_ready_i (M_AXIS_TREADY),
        .rd_valid_o (M_AXIS_TVALID),
        .rd_data_o  (fifo_out),
        .level_o    (fifo_level),
        .overflow_o (overflow)
    );

    assign M_AXIS_TDATA = fifo_out[DATA_W-1:0];
    assign M_AXIS_TKEEP = fifo_out[DATA_W +: BYTES_PER_BEAT];
    assign M_AXIS_TLAST = fifo_out[FIFO_W-1];
    assign frame_err    = frame_err_q;
    assign parity_err   = parity_err_q;

endmodule

// File: tb/tb_uart_rx_axis_packer.sv
// Directed bench: instance A without parity, instance B with even parity.
module tb_uart_rx_axis_packer;

    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_a_n, rst_b_n, rx_a, rx_b, tready_a, tready_b;
    logic        tvalid_a, tlast_a, ferr_a_o, perr_a_o, ovf_a_o;
    logic        tvalid_b, tlast_b, ferr_b_o, perr_b_o, ovf_b_o;
    logic [31:0] tdata_a, tdata_b;
    logic [3:0]  tkeep_a, tkeep_b;
    logic [2:0]  level_a, level_b;

    uart_rx_axis_packer #(
        .CLKS_PER_BIT(CPB), .SYNC_STAGES(3), .BYTES_PER_BEAT(4), .PARITY_EN(0),
        .PARITY_ODD(0), .FIFO_DEPTH(4), .IDLE_TIMEOUT_BITS(20)
    ) dut_a (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_a_n), .rx_din(rx_a),
        .M_AXIS_TREADY(tready_a), .M_AXIS_TVALID(tvalid_a), .M_AXIS_TDATA(tdata_a),
        .M_AXIS_TKEEP(tkeep_a), .M_AXIS_TLAST(tlast_a), .frame_err(ferr_a_o),
        .parity_err(perr_a_o), .overflow(ovf_a_o), .fifo_level(level_a)
    );

    uart_rx_axis_packer #(
        .CLKS_PER_BIT(CPB), .SYNC_STAGES(3), .BYTES_PER_BEAT(4), .PARITY_EN(1),
        .PARITY_ODD(0), .FIFO_DEPTH(4), .IDLE_TIMEOUT_BITS(20)
    ) dut_b (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_b_n), .rx_din(rx_b),
        .M_AXIS_TREADY(tready_b), .M_AXIS_TVALID(tvalid_b), .M_AXIS_TDATA(tdata_b),
        .M_AXIS_TKEEP(tkeep_b), .M_AXIS_TLAST(tlast_b), .frame_err(ferr_b_o),
        .parity_err(perr_b_o), .overflow(ovf_b_o), .fifo_level(level_b)
    );

    logic [36:0] beats_a[$], beats_b[$];
    int unsigned ferr_a = 0, perr_a = 0, ovf_a = 0, vcyc_a = 0, rise_a = 0;
    int unsigned ferr_b = 0, perr_b = 0, ovf_b = 0;
    logic        tv_prev_a = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (tvalid_a) vcyc_a++;
        if (tvalid_a && !tv_prev_a) rise_a = cyc;
        tv_prev_a = tvalid_a;
        if (tvalid_a && tready_a) beats_a.push_back({tlast_a, tkeep_a, tdata_a});
        if (ferr_a_o) ferr_a++;
        if (perr_a_o) perr_a++;
        if (ovf_a_o)  ovf_a++;
        if (tvalid_b && tready_b) beats_b.push_back({tlast_b, tkeep_b, tdata_b});
        if (ferr_b_o) ferr_b++;
        if (perr_b_o) perr_b++;
        if (ovf_b_o)  ovf_b++;
    end

    int unsigned n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int unsigned which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic wait_bits(input int unsigned n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input int unsigned which, input logic [7:0] d, input logic stop_v,
                             input logic par_en, input logic par_v);
        drive(which, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            wait_bits(1);
        end
        if (par_en) begin
            drive(which, par_v);
            wait_bits(1);
        end
        drive(which, stop_v);
        wait_bits(1);
        drive(which, 1'b1);
    endtask

    task automatic send_good_b(input logic [7:0] d);
        send_byte(1, d, 1'b1, 1'b1, ^d);
    endtask

    task automatic wait_beats(input int unsigned which, input int unsigned n, input int unsigned max_cyc);
        for (int unsigned i = 0; i < max_cyc; i++) begin
            if (which == 0 && beats_a.size() >= n) break;
            if (which == 1 && beats_b.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs_a(input string tag);
        check({tag, "_tvalid"}, tvalid_a, 0);
        check({tag, "_tdata"},  tdata_a,  0);
        check({tag, "_tkeep"},  tkeep_a,  0);
        check({tag, "_tlast"},  tlast_a,  0);
        check({tag, "_level"},  level_a,  0);
        check({tag, "_pulses"}, {ferr_a_o, perr_a_o, ovf_a_o}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int unsigned base, fb, pb, ob, vb, t0;

    initial begin
        rx_a = 1'b1; rx_b = 1'b1; tready_a = 1'b1; tready_b = 1'b1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs_a("rst_in");
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs_a("rst_out");
        check("rst_b_tvalid", tvalid_b, 0);

        // 1: full beat, TVALID latency and width
        base = beats_a.size(); fb = ferr_a; pb = perr_a; vb = vcyc_a;
        send_byte(0, 8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h22, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h33, 1'b1, 1'b0, 1'b0);
        t0 = cyc;
        send_byte(0, 8'h44, 1'b1, 1'b0, 1'b0);
        wait_beats(0, base + 1, 200);
        wait_bits(2);
        check("t1_count", beats_a.size() - base, 1);
        check("t1_data",  beats_a[base][31:0], 32'h44332211);
        check("t1_keep",  beats_a[base][35:32], 4'hF);
        check("t1_last",  beats_a[base][36], 1'b0);
        check("t1_vcycles", vcyc_a - vb, 1);
        check("t1_latency", rise_a - t0, 160);
        check("t1_errs", (ferr_a - fb) + (perr_a - pb), 0);
        wait_bits(25);
        check("t1_no_flush_k0", beats_a.size() - base, 1);

        // 2: partial flush on timeout, once per idle period
        base = beats_a.size();
        send_byte(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h5A, 1'b1, 1'b0, 1'b0);
        wait_beats(0, base + 1, 30 * CPB);
        check("t2_count", beats_a.size() - base, 1);
        check("t2_data",  beats_a[base][31:0], 32'h00005AA5);
        check("t2_keep",  beats_a[base][35:32], 4'h3);
        check("t2_last",  beats_a[base][36], 1'b1);
        wait_bits(40);
        check("t2_single_flush", beats_a.size() - base, 1);

        // 3: false start glitch
        base = beats_a.size(); fb = ferr_a; pb = perr_a;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        wait_bits(3);
        check("t3_glitch_nobeat", beats_a.size() - base, 0);
        check("t3_glitch_errs", (ferr_a - fb) + (perr_a - pb), 0);
        send_byte(0, 8'h11, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h22, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h33, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h44, 1'b1, 1'b0, 1'b0);
        wait_beats(0, base + 1, 200);
        check("t3_count", beats_a.size() - base, 1);
        check("t3_data",  beats_a[base][31:0], 32'h44332211);
        check("t3_keep",  beats_a[base][35:32], 4'hF);

        // 4: framing error then break
        base = beats_a.size(); fb = ferr_a;
        send_byte(0, 8'h7E, 1'b0, 1'b0, 1'b0);
        rx_a = 1'b0;
        wait_bits(3);
        rx_a = 1'b1;
        wait_bits(1);
        send_byte(0, 8'h01, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h02, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h03, 1'b1, 1'b0, 1'b0);
        send_byte(0, 8'h04, 1'b1, 1'b0, 1'b0);
        wait_beats(0, base + 1, 200);
        check("t4_frame_err", ferr_a - fb, 1);
        check("t4_count", beats_a.size() - base, 1);
        check("t4_data",  beats_a[base][31:0], 32'h04030201);
        check("t4_last",  beats_a[base][36], 1'b0);
        wait_bits(25);

        // 5: back-pressure, overflow, stall stability
        tready_a = 1'b0;
        base = beats_a.size(); ob = ovf_a;
        for (int i = 0; i < 20; i++) send_byte(0, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        wait_bits(2);
        check("t5_level", level_a, 4);
        check("t5_overflow", ovf_a - ob, 1);
        check("t5_nopop", beats_a.size() - base, 0);
        for (int i = 0; i < 4; i++) begin
            check("t5_stall_tdata", tdata_a, 32'h13121110);
            check("t5_stall_tvalid", tvalid_a, 1'b1);
            @(negedge clk);
        end
        tready_a = 1'b1;
        wait_beats(0, base + 4, 50);
        repeat (5) @(negedge clk);
        check("t5_count", beats_a.size() - base, 4);
        check("t5_beat0", beats_a[base][31:0],     32'h13121110);
        check("t5_beat1", beats_a[base + 1][31:0], 32'h17161514);
        check("t5_beat2", beats_a[base + 2][31:0], 32'h1B1A1918);
        check("t5_beat3", beats_a[base + 3][31:0], 32'h1F1E1D1C);
        check("t5_level_after", level_a, 0);

        // 6: parity error and mid-byte reset (instance B)
        base = beats_b.size(); pb = perr_b; fb = ferr_b;
        send_byte(1, 8'h03, 1'b1, 1'b1, 1'b1);
        wait_bits(2);
        check("t6_parity_err", perr_b - pb, 1);
        check("t6_no_frame_err", ferr_b - fb, 0);
        check("t6_dropped", beats_b.size() - base, 0);
        tready_b = 1'b0;
        send_good_b(8'h01);
        send_good_b(8'h02);
        send_good_b(8'h03);
        send_good_b(8'h04);
        wait_bits(2);
        check("t6_pre_tvalid", tvalid_b, 1'b1);
        check("t6_pre_level", level_b, 1);
        send_good_b(8'hAA);
        rx_b = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx_b = i[0];
            wait_bits(1);
        end
        rst_b_n = 1'b0;
        #1;
        check("t6_rst_tvalid", tvalid_b, 0);
        check("t6_rst_level",  level_b, 0);
        check("t6_rst_tdata",  tdata_b, 0);
        check("t6_rst_tkeep",  tkeep_b, 0);
        check("t6_rst_pulses", {tlast_b, ferr_b_o, perr_b_o, ovf_b_o}, 0);
        @(negedge clk);
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
        tready_b = 1'b1;
        base = beats_b.size();
        wait_bits(2);
        send_good_b(8'h05);
        send_good_b(8'h06);
        send_good_b(8'h07);
        send_good_b(8'h08);
        wait_beats(1, base + 1, 200);
        wait_bits(25);
        check("t6_count", beats_b.size() - base, 1);
        check("t6_data",  beats_b[base][31:0], 32'h08070605);
        check("t6_keep",  beats_b[base][35:32], 4'hF);
        check("t6_last",  beats_b[base][36], 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis_packer.md
Name: uart_rx_axis_packer

Overview:
Parametrised UART receiver that feeds an AXI4-Stream master.
- Oversamples a synchronised serial line and validates start, parity and stop bits.
- Packs bytes little-endian into BYTES_PER_BEAT-wide beats.
- Buffers beats in a small FIFO so that TREADY back-pressure does not lose data.
- On line-idle timeout, flushes a partial beat with TKEEP and TLAST.
- Sits between the board RX pin and the DMA/stream fabric.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (min 4).
SYNC_STAGES, 3, synchroniser flops on rx_din (min 2).
BYTES_PER_BEAT, 4, bytes per TDATA beat (1..8).
PARITY_EN, 0, 1 = parity bit expected after the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0).
FIFO_DEPTH, 4, output FIFO depth in beats (power of 2, min 2).
IDLE_TIMEOUT_BITS, 20, idle bit-times before a partial flush; 0 disables flushing.

Ports:
M_AXIS_ACLK  in  1  clock
M_AXIS_ARESETN  in  1  reset, asynchronous, active-low
rx_din  in  1  asynchronous serial input, idle high
M_AXIS_TREADY  in  1  downstream ready
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TDATA  out  8*BYTES_PER_BEAT  packed bytes, byte 0 in [7:0]
M_AXIS_TKEEP  out  BYTES_PER_BEAT  valid byte lanes
M_AXIS_TLAST  out  1  set on timeout-flushed beat
frame_err  out  1  one-cycle pulse, stop bit sampled low
parity_err  out  1  one-cycle pulse, parity mismatch
overflow  out  1  one-cycle pulse, beat dropped because FIFO full
fifo_level  out  $clog2(FIFO_DEPTH)+1  beats currently stored

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; fifo_level 0.
  - Synchroniser flops reset to 1 (idle line).
  - Receiver FSM returns to IDLE; packer and FIFO are emptied.
  - Reset mid-byte or mid-beat discards the partial data; there is no stale beat afterwards.
- Receiver FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a 1->0 edge on the synchronised line goes to START and clears the bit counter.
  - START: at count CLKS_PER_BIT/2 (integer), sample the line.
    - Low: go to DATA with the counter reset.
    - High: false start; return to IDLE with no pulse.
  - DATA: sample every CLKS_PER_BIT cycles (bit centre), 8 bits, LSB first. Then go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample one bit and compare it with the XOR of the data bits (inverted when PARITY_ODD).
  - STOP: sample the stop bit.
    - High and parity ok: byte accepted; go to IDLE.
    - Low: frame_err pulse, byte dropped, go to BREAK.
    - Parity bad with stop high: parity_err pulse, byte dropped, go to IDLE.
    - Both errors: both pulses fire; byte dropped; go to BREAK.
  - BREAK: wait for the synchronised line to be high, then go to IDLE. No start edge is detected while low.
- Packer:
  - An accepted byte is written to lane k (bits 8k+7:8k) on the cycle after the stop sample; k then increments.
  - When k reaches BYTES_PER_BEAT, the beat is pushed with TKEEP all ones and TLAST=0, and k returns to 0. The push happens 2 cycles after the stop sample.
- Idle timeout:
  - The counter clears on every start edge and counts while FSM is IDLE.
  - At IDLE_TIMEOUT_BITS*CLKS_PER_BIT with k>0: push a beat with TKEEP = (1<<k)-1, unused lanes zero, TLAST=1, then k=0.
  - With k=0 at timeout: no beat is pushed.
  - The counter saturates, so one flush occurs per idle period.
- FIFO and AXI-Stream:
  - First-word fall-through; TVALID = fifo_level != 0.
  - TDATA, TKEEP and TLAST are held stable while TVALID && !TREADY.
  - A pop occurs on TVALID && TREADY.
  - Empty FIFO: TVALID rises 3 cycles after the stop sample of the completing byte.
  - Push while full without a pop in the same cycle: beat dropped, overflow pulse, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
- Width rules:
  - All counters sized with $clog2 of their maximum.
  - The timeout counter is wide enough for IDLE_TIMEOUT_BITS*CLKS_PER_BIT.
  - No counter wraps silently.

Decomposition:
- Package uart_axis_pkg holds:
  - the FSM state enum;
  - the byte width constant (8);
  - a parity function (data, odd) -> expected bit.
- One sub-module, axis_sync_fifo, parametrised by width (8*BPB + BPB + 1) and depth, with a FWFT output.
- Synchroniser, FSM, packer and timeout logic stay in the top module.

Test Plan:
All tests use CLKS_PER_BIT=16 and IDLE_TIMEOUT_BITS=20 unless noted.
1. Send 0x11, 0x22, 0x33, 0x44 with TREADY=1 -> one beat: TDATA=0x44332211, TKEEP=0xF, TLAST=0, TVALID high for exactly 1 cycle. No error pulses.
2. Send 0xA5, 0x5A, then idle for 20 bit-times -> one beat: TDATA=0x00005AA5, TKEEP=0x3, TLAST=1. A further idle period produces no beat.
3. Drive rx_din low for 4 cycles, then high -> no byte, no pulses, FSM back in IDLE. Then send 0x11, 0x22, 0x33, 0x44 -> the next beat is 0x44332211, with no extra lane from the glitch.
4. Send 0x7E with the stop bit forced low, line low for 3 bit-times, then 0x01, 0x02, 0x03, 0x04 -> one frame_err pulse; beat TDATA=0x04030201 with no 0x7E lane.
5. FIFO_DEPTH=4, TREADY=0, send 20 bytes -> fifo_level=4 and one overflow pulse. Then TREADY=1 -> 4 beats out in order, with TDATA held constant during the stall.
6. PARITY_EN=1, even parity: send 0x03 with parity bit 1 -> parity_err pulse, byte dropped. Also assert reset mid-byte -> all outputs 0 at once, and the next clean 4 bytes give one correct beat.
